// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Round-robin sharing of one BRAM port between two requesters,
//             with credit-protected per-requester read response FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic                  r0_req_write,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_data,
    output logic                  r0_resp_valid,
    input  logic                  r0_resp_ready,
    output logic [DATA_WIDTH-1:0] r0_resp_data,

    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic                  r1_req_write,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_data,
    output logic                  r1_resp_valid,
    input  logic                  r1_resp_ready,
    output logic [DATA_WIDTH-1:0] r1_resp_data,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int c_PW = $clog2(RESP_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_OW = c_CW + 1;
    localparam logic [c_OW-1:0] c_DEPTH_O = c_OW'(RESP_DEPTH);
    localparam logic [c_CW-1:0] c_DEPTH_C = c_CW'(RESP_DEPTH);

    logic [1:0]                  w_req_valid;
    logic [1:0]                  w_req_write;
    logic [1:0]                  w_resp_ready;
    logic [1:0][ADDR_WIDTH-1:0]  w_req_addr;
    logic [1:0][DATA_WIDTH-1:0]  w_req_data;
    logic [1:0][DATA_WIDTH-1:0]  w_resp_data;
    logic [1:0]                  w_resp_valid;
    logic [1:0]                  w_elig;
    logic [1:0]                  w_grant;
    logic [1:0]                  w_push;
    logic [1:0][c_OW-1:0]        w_outstanding;

    logic                        r_prio;
    logic                        w_gnt_any;
    logic                        w_gnt_id;
    logic                        w_gnt_read;
    logic                        w_push_any;
    logic                        w_push_id;
    logic [READ_LATENCY-1:0]     r_pipe_valid;
    logic [READ_LATENCY-1:0]     r_pipe_id;

    assign w_req_valid  = {r1_req_valid,  r0_req_valid};
    assign w_req_write  = {r1_req_write,  r0_req_write};
    assign w_resp_ready = {r1_resp_ready, r0_resp_ready};
    assign w_req_addr   = {r1_req_addr,   r0_req_addr};
    assign w_req_data   = {r1_req_data,   r0_req_data};

    // Reset gates the grant so ready and bram_en fall as soon as RST_N does.
    always_comb begin
        w_grant = '0;
        if (RST_N) begin
            if (w_elig[r_prio]) begin
                w_grant[r_prio] = 1'b1;
            end else if (w_elig[~r_prio]) begin
                w_grant[~r_prio] = 1'b1;
            end
        end
    end

    assign w_gnt_any  = |w_grant;
    assign w_gnt_id   = w_grant[1];
    assign w_gnt_read = w_gnt_any & ~w_req_write[w_gnt_id];

    assign r0_req_ready = w_grant[0];
    assign r1_req_ready = w_grant[1];

    assign bram_en   = w_gnt_any;
    assign bram_we   = w_gnt_any & w_req_write[w_gnt_id];
    assign bram_addr = w_gnt_any ? w_req_addr[w_gnt_id] : '0;
    assign bram_din  = w_gnt_any ? w_req_data[w_gnt_id] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prio <= 1'b0;
        end else if (w_gnt_any) begin
            r_prio <= ~w_gnt_id;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pipe_valid <= '0;
            r_pipe_id    <= '0;
        end else begin
            r_pipe_valid[0] <= w_gnt_read;
            r_pipe_id[0]    <= w_gnt_id;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
                r_pipe_id[k]    <= r_pipe_id[k-1];
            end
        end
    end

    assign w_push_any = r_pipe_valid[READ_LATENCY-1];
    assign w_push_id  = r_pipe_id[READ_LATENCY-1];
    assign w_push[0]  = w_push_any & ~w_push_id;
    assign w_push[1]  = w_push_any &  w_push_id;

    for (genvar g = 0; g < 2; g++) begin : g_req
        logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
        logic [c_PW-1:0]       r_wptr;
        logic [c_PW-1:0]       r_rptr;
        logic [c_CW-1:0]       r_count;
        logic [c_CW-1:0]       r_inflight;
        logic                  w_pop;
        logic                  w_issue;

        assign w_pop            = (r_count != '0) && w_resp_ready[g];
        assign w_issue          = w_grant[g] && !w_req_write[g];
        assign w_resp_valid[g]  = (r_count != '0);
        assign w_resp_data[g]   = r_mem[r_rptr];
        // Credits come only from registered state, so a pop frees space one cycle later.
        assign w_outstanding[g] = c_OW'(r_count) + c_OW'(r_inflight);
        assign w_elig[g]        = w_req_valid[g] &&
                                  (w_req_write[g] || (w_outstanding[g] < c_DEPTH_O));

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_inflight <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wptr <= r_wptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PW'(1);
                end
                if (w_push[g] && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (!w_push[g] && w_pop) begin
                    r_count <= r_count - c_CW'(1);
                end
                if (w_issue && !w_push[g]) begin
                    r_inflight <= r_inflight + c_CW'(1);
                end else if (!w_issue && w_push[g]) begin
                    r_inflight <= r_inflight - c_CW'(1);
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (w_push[g]) begin
                r_mem[r_wptr] <= bram_dout;
            end
        end

        always @(posedge CLK) begin
            if (RST_N && w_push[g]) begin
                a_no_overflow : assert (r_count < c_DEPTH_C);
                a_has_credit  : assert (r_inflight != '0);
            end
        end
    end

    assign r0_resp_valid = w_resp_valid[0];
    assign r1_resp_valid = w_resp_valid[1];
    assign r0_resp_data  = w_resp_data[0];
    assign r1_resp_data  = w_resp_data[1];

endmodule
`default_nettype wire
